// File: rtl/softmax_normalizer.sv
// softmax_normalizer
//   Collects one softmax row of N unsigned exponential values, accumulates
//   their sum, then emits each value divided by the row sum as an unsigned
//   fixed-point probability with OW fraction bits (2^OW-1 ~ 1.0). Division is
//   a sequential restoring divider producing one quotient bit per cycle.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_flush          synchronous abort: back to COLLECT, row discarded
//   i_valid/i_ready  input handshake (ready only while collecting)
//   i_data [DW]      exponential value, unsigned
//   o_valid/o_ready  output handshake; outputs held until accepted
//   o_data [OW]      normalized probability, saturated to 2^OW-1
//   o_last           element N-1 of the row (qualified by o_valid)
//   o_zero           row sum was zero (qualified by o_valid)
//   busy             high whenever not collecting
module softmax_normalizer #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          o_last,
  output logic          o_zero,
  output logic          busy
);

  localparam int SW = DW + $clog2(N);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(OW + 2);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LOAD    = 2'd1,
    S_DIV     = 2'd2,
    S_OUT     = 2'd3
  } state_e;

  // Saturate the (OW+1)-bit quotient: exactly 1.0 (2^OW) maps to 2^OW-1.
  function automatic logic [OW-1:0] sat_q(input logic [OW:0] q);
    logic [OW-1:0] r;
    if (q[OW]) begin
      r = {OW{1'b1}};
    end else begin
      r = q[OW-1:0];
    end
    return r;
  endfunction

  state_e         state_r, state_nx_s;
  logic [DW-1:0]  buf_mem_r [N];
  logic [DW-1:0]  buf_s;
  logic [SW-1:0]  sum_r;
  logic [IW-1:0]  wr_idx_r, rd_idx_r;
  logic [CW-1:0]  cnt_r;
  logic [SW:0]    rem_r;
  logic [OW:0]    dvd_r;
  logic [OW-1:0]  q_r;
  logic [SW:0]    rem_shift_s, rem_sub_s, rem_nx_s;
  logic           rem_ge_s;
  logic [OW:0]    q_step_s;
  logic           xfer_s, hs_s;
  logic           last_rd_s, last_wr_s;
  logic [OW-1:0]  out_data_ld_s;
  logic           out_zero_ld_s, out_last_ld_s;
  logic           o_valid_r, i_ready_r, busy_r, o_last_r, o_zero_r;
  logic [OW-1:0]  o_data_r;

  assign buf_s     = buf_mem_r[rd_idx_r];
  assign last_wr_s = (wr_idx_r == IW'(N - 1));
  assign last_rd_s = (rd_idx_r == IW'(N - 1));
  assign xfer_s    = i_valid && (state_r == S_COLLECT) && !i_flush;
  assign hs_s      = (state_r == S_OUT) && o_ready;

  assign i_ready = i_ready_r;
  assign o_valid = o_valid_r;
  assign o_data  = o_data_r;
  assign o_last  = o_last_r;
  assign o_zero  = o_zero_r;
  assign busy    = busy_r;

  // One restoring-division step on the current remainder.
  always_comb begin
    rem_shift_s = (rem_r << 1) | {{SW{1'b0}}, dvd_r[OW]};
    rem_ge_s    = (rem_shift_s >= {1'b0, sum_r});
    rem_sub_s   = rem_shift_s - {1'b0, sum_r};
    if (rem_ge_s) begin
      rem_nx_s = rem_sub_s;
    end else begin
      rem_nx_s = rem_shift_s;
    end
    q_step_s = {q_r, rem_ge_s};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; flush overrides every transition.
  always_comb begin
    state_nx_s = state_r;
    if (i_flush) begin
      state_nx_s = S_COLLECT;
    end else begin
      case (state_r)
        S_COLLECT: begin
          if (i_valid && last_wr_s) begin
            state_nx_s = S_LOAD;
          end else begin
            state_nx_s = S_COLLECT;
          end
        end
        S_LOAD: begin
          if (sum_r == '0) begin
            state_nx_s = S_OUT;
          end else begin
            state_nx_s = S_DIV;
          end
        end
        S_DIV: begin
          if (cnt_r == CW'(1)) begin
            state_nx_s = S_OUT;
          end else begin
            state_nx_s = S_DIV;
          end
        end
        S_OUT: begin
          if (!o_ready) begin
            state_nx_s = S_OUT;
          end else if (last_rd_s) begin
            state_nx_s = S_COLLECT;
          end else begin
            state_nx_s = S_LOAD;
          end
        end
        default: state_nx_s = S_COLLECT;
      endcase
    end
  end

  // FSM output logic: values captured into the output registers on OUT entry.
  // OUT is entered only from LOAD (zero-sum row) or from the last DIV step.
  always_comb begin
    out_last_ld_s = last_rd_s;
    if (state_r == S_LOAD) begin
      out_data_ld_s = {OW{1'b0}};
      out_zero_ld_s = 1'b1;
    end else begin
      out_data_ld_s = sat_q(q_step_s);
      out_zero_ld_s = 1'b0;
    end
  end

  // Registered outputs, loaded on OUT entry and held until the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid_r <= 1'b0;
      i_ready_r <= 1'b1;
      busy_r    <= 1'b0;
      o_data_r  <= {OW{1'b0}};
      o_last_r  <= 1'b0;
      o_zero_r  <= 1'b0;
    end else begin
      o_valid_r <= (state_nx_s == S_OUT);
      i_ready_r <= (state_nx_s == S_COLLECT);
      busy_r    <= (state_nx_s != S_COLLECT);
      if (state_nx_s == S_OUT) begin
        if (state_r != S_OUT) begin
          o_data_r <= out_data_ld_s;
          o_last_r <= out_last_ld_s;
          o_zero_r <= out_zero_ld_s;
        end else begin
          o_data_r <= o_data_r;
          o_last_r <= o_last_r;
          o_zero_r <= o_zero_r;
        end
      end else begin
        o_data_r <= {OW{1'b0}};
        o_last_r <= 1'b0;
        o_zero_r <= 1'b0;
      end
    end
  end

  // Row buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      buf_mem_r[wr_idx_r] <= i_data;
    end
  end

  // Datapath: accumulation, indices and divider registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_r    <= {SW{1'b0}};
      wr_idx_r <= {IW{1'b0}};
      rd_idx_r <= {IW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      rem_r    <= {(SW + 1){1'b0}};
      dvd_r    <= {(OW + 1){1'b0}};
      q_r      <= {OW{1'b0}};
    end else if (i_flush) begin
      sum_r    <= {SW{1'b0}};
      wr_idx_r <= {IW{1'b0}};
      rd_idx_r <= {IW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_COLLECT: begin
          if (xfer_s) begin
            sum_r <= sum_r + SW'(i_data);
            if (last_wr_s) begin
              wr_idx_r <= {IW{1'b0}};
            end else begin
              wr_idx_r <= wr_idx_r + IW'(1);
            end
          end
        end
        S_LOAD: begin
          // Dividend is {buf, OW zeros}. Because buf <= sum, all quotient bits
          // above OW are zero, so the restoring steps for them would just
          // shift dividend bits into the remainder: preload it with buf>>1
          // and keep only the last OW+1 dividend bits to shift in.
          rem_r <= (SW + 1)'(buf_s >> 1);
          dvd_r <= {buf_s[0], {OW{1'b0}}};
          q_r   <= {OW{1'b0}};
          cnt_r <= CW'(OW + 1);
        end
        S_DIV: begin
          rem_r <= rem_nx_s;
          dvd_r <= dvd_r << 1;
          q_r   <= q_step_s[OW-1:0];
          cnt_r <= cnt_r - CW'(1);
        end
        S_OUT: begin
          if (hs_s) begin
            if (last_rd_s) begin
              rd_idx_r <= {IW{1'b0}};
              sum_r    <= {SW{1'b0}};
            end else begin
              rd_idx_r <= rd_idx_r + IW'(1);
            end
          end
        end
        default: begin
          sum_r <= {SW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
module tb_softmax_normalizer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int OW = 8;

  logic          clk;
  logic          rstn;
  logic          i_flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [OW-1:0] o_data;
  logic          o_last;
  logic          o_zero;
  logic          busy;

  int checks;
  int failures;

  softmax_normalizer #(.DW(DW), .N(N), .OW(OW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_zero  (o_zero),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din  [4];
    logic [7:0]  dout [4];
    bit          zero;
  } row_t;

  row_t rows [6];

  function automatic row_t mk(input int a0, a1, a2, a3, e0, e1, e2, e3, input bit z);
    row_t r;
    r.din[0] = 16'(a0); r.din[1] = 16'(a1); r.din[2] = 16'(a2); r.din[3] = 16'(a3);
    r.dout[0] = 8'(e0); r.dout[1] = 8'(e1); r.dout[2] = 8'(e2); r.dout[3] = 8'(e3);
    r.zero = z;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; the transfer happens on the posedge between.
  task automatic push(input int v);
    int g;
    g = 0;
    i_valid = 1'b1;
    i_data  = 16'(v);
    while (!i_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!i_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Counts negedges until o_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_row(input row_t r);
    int cyc;
    for (int k = 0; k < 4; k++) push(int'(r.din[k]));
    for (int k = 0; k < 4; k++) begin
      wait_valid(cyc);
      if (k == 0) chk("first_latency", cyc, r.zero ? 1 : OW + 2);
      else        chk("output_gap", cyc + 1, r.zero ? 2 : OW + 3);
      chk("o_data", int'(o_data), int'(r.dout[k]));
      chk("o_last", int'(o_last), (k == 3) ? 1 : 0);
      chk("o_zero", int'(o_zero), r.zero ? 1 : 0);
      chk("busy_out", int'(busy), 1);
      chk("i_ready_out", int'(i_ready), 0);
      @(negedge clk);
      chk("valid_drop", int'(o_valid), 0);
    end
    chk("i_ready_after_row", int'(i_ready), 1);
    chk("busy_after_row", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    int bp_exp [4];
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    i_flush  = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    o_ready  = 1'b1;

    rows[0] = mk(1, 1, 1, 1, 64, 64, 64, 64, 1'b0);
    rows[1] = mk(4, 0, 0, 0, 255, 0, 0, 0, 1'b0);
    rows[2] = mk(3, 1, 0, 0, 192, 64, 0, 0, 1'b0);
    rows[3] = mk(65535, 65535, 65535, 65535, 64, 64, 64, 64, 1'b0);
    rows[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    rows[5] = mk(2, 2, 0, 0, 128, 128, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_i_ready", int'(i_ready), 1);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_o_last", int'(o_last), 0);
    chk("rst_o_zero", int'(o_zero), 0);
    chk("rst_busy", int'(busy), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Backpressure: each output held 5 cycles, ignored input presented meanwhile.
    bp_exp[0] = 32; bp_exp[1] = 64; bp_exp[2] = 96; bp_exp[3] = 64;
    o_ready = 1'b0;
    push(1); push(2); push(3); push(2);
    for (int k = 0; k < 4; k++) begin
      wait_valid(cyc);
      i_valid = 1'b1;
      i_data  = 16'd999;
      for (int h = 0; h < 5; h++) begin
        @(negedge clk);
        chk("bp_valid", int'(o_valid), 1);
        chk("bp_data", int'(o_data), bp_exp[k]);
        chk("bp_last", int'(o_last), (k == 3) ? 1 : 0);
        chk("bp_i_ready", int'(i_ready), 0);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      chk("bp_valid_drop", int'(o_valid), 0);
    end
    o_ready = 1'b1;
    run_row(rows[2]);

    // Asynchronous reset in the middle of DIV.
    for (int k = 0; k < 4; k++) push(3);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("abort_rst_valid", int'(o_valid), 0);
    chk("abort_rst_busy", int'(busy), 0);
    chk("abort_rst_ready", int'(i_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_row(rows[0]);

    // Flush in the middle of DIV, with an input presented in the same cycle.
    for (int k = 0; k < 4; k++) push(7);
    repeat (3) @(negedge clk);
    chk("pre_flush_busy", int'(busy), 1);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 16'd500;
    @(negedge clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_div_valid", int'(o_valid), 0);
    chk("flush_div_busy", int'(busy), 0);
    chk("flush_div_ready", int'(i_ready), 1);
    run_row(rows[0]);

    // Flush of a partially collected row, and flush while an output waits.
    push(5); push(7);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    o_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(1);
    wait_valid(cyc);
    chk("partial_flush_data", int'(o_data), 64);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_out_valid", int'(o_valid), 0);
    chk("flush_out_busy", int'(busy), 0);
    o_ready = 1'b1;
    run_row(rows[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
